// File: rtl/bomb_round_judge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bomb_round_judge: times code display / defuse window, judges the entry.  |
// | Optional macro ATTEMPT_LIMIT_EN enables MAX_TRIES wrong entries.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bomb_round_judge #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int SHOW_SEC   = 5,
    parameter int LIMIT_SEC  = 20,
    parameter int RESULT_SEC = 3,
    parameter int MAX_TRIES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       showing,
    input  logic       start,
    input  logic       startInput,
    input  logic [4:0] random,
    input  logic [4:0] code_in,
    input  logic       BTN0,
    output logic       endOfShow,
    output logic       infail,
    output logic       insuccess,
    output logic       repeatRst,
    output logic [4:0] sec_left,
    output logic [2:0] tries_left
);

    localparam int            CW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_TICK_MAX   = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_CNT_ONE    = CW'(1);
    localparam logic [4:0]    C_SHOW_SEC   = 5'(SHOW_SEC);
    localparam logic [4:0]    C_LIMIT_SEC  = 5'(LIMIT_SEC);
    localparam logic [4:0]    C_RESULT_SEC = 5'(RESULT_SEC);
    localparam logic [2:0]    C_MAX_TRIES  = 3'(MAX_TRIES);
`ifdef ATTEMPT_LIMIT_EN
    localparam logic          C_LIMIT_EN   = 1'b1;
`else
    localparam logic          C_LIMIT_EN   = 1'b0;
`endif
    // Without the attempt limit, tries_left simply reads 1 during a round.
    localparam logic [2:0]    C_TRIES_LOAD = C_LIMIT_EN ? C_MAX_TRIES : 3'd1;
    localparam logic [2:0]    C_TRY_STEP   = {2'b00, C_LIMIT_EN};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHOW    = 3'd1,
        S_ARMED   = 3'd2,
        S_SUCCESS = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    code_q;
    logic [4:0]    sec_q;
    logic [2:0]    tries_q;
    logic          btn_q;
    logic          eos_q;
    logic          fail_q;
    logic          succ_q;
    logic          rr_q;

    logic w_tick, w_submit, w_go, w_hit, w_miss_last, w_dec, w_last_sec;

    assign w_tick      = (cnt_q == C_TICK_MAX);
    assign w_submit    = BTN0 & ~btn_q;
    assign w_go        = w_submit & startInput;
    assign w_hit       = w_go & (code_in == code_q);
    assign w_miss_last = w_go & (code_in != code_q) & (!C_LIMIT_EN || (tries_q <= 3'd1));
    assign w_dec       = start & w_tick;
    assign w_last_sec  = (sec_q == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            sec_q   <= '0;
            tries_q <= '0;
            btn_q   <= 1'b0;
            eos_q   <= 1'b0;
            fail_q  <= 1'b0;
            succ_q  <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            btn_q <= BTN0;
            rr_q  <= 1'b0;
            if (state_q != S_IDLE && !showing) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                sec_q   <= '0;
                tries_q <= '0;
                eos_q   <= 1'b0;
                fail_q  <= 1'b0;
                succ_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                        if (showing) begin
                            state_q <= S_SHOW;
                            code_q  <= random;
                            sec_q   <= C_SHOW_SEC;
                            tries_q <= C_TRIES_LOAD;
                        end
                    end
                    S_SHOW: begin
                        cnt_q <= w_tick ? '0 : cnt_q + C_CNT_ONE;
                        if (w_tick) begin
                            if (w_last_sec) begin
                                state_q <= S_ARMED;
                                eos_q   <= 1'b1;
                                sec_q   <= C_LIMIT_SEC;
                            end else begin
                                sec_q <= sec_q - 5'd1;
                            end
                        end
                    end
                    S_ARMED: begin
                        // The tick counter is frozen along with the countdown.
                        if (start) cnt_q <= w_tick ? '0 : cnt_q + C_CNT_ONE;
                        if (w_hit) begin
                            state_q <= S_SUCCESS;
                            succ_q  <= 1'b1;
                            sec_q   <= C_RESULT_SEC;
                            cnt_q   <= '0;
                        end else if (w_miss_last || (w_dec && w_last_sec)) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                            sec_q   <= C_RESULT_SEC;
                            cnt_q   <= '0;
                            if (w_go) tries_q <= tries_q - C_TRY_STEP;
                        end else begin
                            if (w_go)  tries_q <= tries_q - C_TRY_STEP;
                            if (w_dec) sec_q   <= sec_q - 5'd1;
                        end
                    end
                    S_SUCCESS, S_FAIL: begin
                        cnt_q <= w_tick ? '0 : cnt_q + C_CNT_ONE;
                        if (w_tick) begin
                            if (w_last_sec) begin
                                state_q <= S_IDLE;
                                rr_q    <= 1'b1;
                                cnt_q   <= '0;
                                sec_q   <= '0;
                                tries_q <= '0;
                                eos_q   <= 1'b0;
                                fail_q  <= 1'b0;
                                succ_q  <= 1'b0;
                            end else begin
                                sec_q <= sec_q - 5'd1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign endOfShow  = eos_q;
    assign infail     = fail_q;
    assign insuccess  = succ_q;
    assign repeatRst  = rr_q;
    assign sec_left   = sec_q;
    assign tries_left = tries_q;

endmodule
`default_nettype wire

// File: tb/tb_bomb_round_judge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bomb_round_judge: self-checking bench for bomb_round_judge.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bomb_round_judge;

    localparam int TICK_DIV = 4;
`ifdef ATTEMPT_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif
    localparam logic [2:0] TR_ACT = LIMIT_EN ? 3'd3 : 3'd1;

    logic       clk;
    logic       rst_n;
    logic       showing;
    logic       start;
    logic       startInput;
    logic [4:0] random;
    logic [4:0] code_in;
    logic       BTN0;
    logic       endOfShow;
    logic       infail;
    logic       insuccess;
    logic       repeatRst;
    logic [4:0] sec_left;
    logic [2:0] tries_left;

    bomb_round_judge #(
        .TICK_DIV   (TICK_DIV),
        .SHOW_SEC   (5),
        .LIMIT_SEC  (20),
        .RESULT_SEC (3),
        .MAX_TRIES  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .showing    (showing),
        .start      (start),
        .startInput (startInput),
        .random     (random),
        .code_in    (code_in),
        .BTN0       (BTN0),
        .endOfShow  (endOfShow),
        .infail     (infail),
        .insuccess  (insuccess),
        .repeatRst  (repeatRst),
        .sec_left   (sec_left),
        .tries_left (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       eos;
        logic       fl;
        logic       sc;
        logic       rr;
        logic [4:0] sec;
        logic [2:0] tr;
    } exp_t;

    typedef struct {
        logic [4:0] rnd;
        logic [4:0] code;
        logic       si;
        logic       sc;
        logic       fl;
        logic [2:0] tr;
        logic [4:0] sec;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic expect_out(input string tag, input logic eos, input logic fl,
                              input logic sc, input logic rr,
                              input logic [4:0] sec, input logic [2:0] tr);
        exp_t e;
        e.tag = tag; e.eos = eos; e.fl = fl; e.sc = sc; e.rr = rr; e.sec = sec; e.tr = tr;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = sb_q.pop_front();
        if ({endOfShow, infail, insuccess, repeatRst, sec_left, tries_left} !==
            {e.eos, e.fl, e.sc, e.rr, e.sec, e.tr}) begin
            n_errors++;
            $display("FAIL %s: got eos=%0b fail=%0b succ=%0b rr=%0b sec=%0d tries=%0d, want eos=%0b fail=%0b succ=%0b rr=%0b sec=%0d tries=%0d",
                     e.tag, endOfShow, infail, insuccess, repeatRst, sec_left, tries_left,
                     e.eos, e.fl, e.sc, e.rr, e.sec, e.tr);
        end
    endtask

    task automatic cyc_check();
        @(negedge clk);
        pop_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; showing = 1'b0; start = 1'b0; startInput = 1'b0;
        BTN0 = 1'b0; code_in = 5'd0; random = 5'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Enters SHOW, then follows the display phase up to the first ARMED cycle.
    task automatic start_round(input logic [4:0] rnd, input string tag);
        showing = 1'b1;
        random  = rnd;
        expect_out({tag, "_show"}, 0, 0, 0, 0, 5'd5, TR_ACT);
        cyc_check();
        random = ~rnd;
        repeat (18) @(negedge clk);
        expect_out({tag, "_show_last"}, 0, 0, 0, 0, 5'd1, TR_ACT);
        cyc_check();
        expect_out({tag, "_armed"}, 1, 0, 0, 0, 5'd20, TR_ACT);
        cyc_check();
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{5'd19, 5'd19, 1'b1, 1'b1, 1'b0, TR_ACT, 5'd3};
        vt[1] = '{5'd19, 5'd7,  1'b1, 1'b0, ~LIMIT_EN, (LIMIT_EN ? 3'd2 : 3'd1), (LIMIT_EN ? 5'd20 : 5'd3)};
        vt[2] = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b0, TR_ACT, 5'd3};
        vt[3] = '{5'd31, 5'd30, 1'b1, 1'b0, ~LIMIT_EN, (LIMIT_EN ? 3'd2 : 3'd1), (LIMIT_EN ? 5'd20 : 5'd3)};
        vt[4] = '{5'd19, 5'd19, 1'b0, 1'b0, 1'b0, TR_ACT, 5'd20};

        rst_n = 1'b0; showing = 1'b0; start = 1'b0; startInput = 1'b0;
        random = 5'd0; code_in = 5'd0; BTN0 = 1'b0;
        expect_out("reset", 0, 0, 0, 0, 5'd0, 3'd0);
        cyc_check();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            start_round(vt[i].rnd, $sformatf("vec%0d", i));
            start = 1'b1; startInput = vt[i].si; code_in = vt[i].code; BTN0 = 1'b1;
            expect_out($sformatf("vec%0d_submit", i), 1, vt[i].fl, vt[i].sc, 0, vt[i].sec, vt[i].tr);
            cyc_check();
            BTN0 = 1'b0;
        end

        // Success, result hold, restart pulse and automatic new round.
        do_reset();
        start_round(5'd19, "A");
        start = 1'b1; startInput = 1'b1; code_in = 5'd19; BTN0 = 1'b1;
        expect_out("A_success", 1, 0, 1, 0, 5'd3, TR_ACT);
        cyc_check();
        BTN0 = 1'b0;
        repeat (10) @(negedge clk);
        expect_out("A_hold_last", 1, 0, 1, 0, 5'd1, TR_ACT);
        cyc_check();
        expect_out("A_repeat_pulse", 0, 0, 0, 1, 5'd0, 3'd0);
        cyc_check();
        expect_out("A_restart", 0, 0, 0, 0, 5'd5, TR_ACT);
        cyc_check();

        // Timeout with no submit.
        do_reset();
        start_round(5'd19, "B");
        start = 1'b1; startInput = 1'b1; code_in = 5'd0;
        repeat (39) @(negedge clk);
        expect_out("B_mid", 1, 0, 0, 0, 5'd10, TR_ACT);
        cyc_check();
        repeat (38) @(negedge clk);
        expect_out("B_last_sec", 1, 0, 0, 0, 5'd1, TR_ACT);
        cyc_check();
        expect_out("B_timeout", 1, 1, 0, 0, 5'd3, TR_ACT);
        cyc_check();

        // Correct submit on the final tick.
        do_reset();
        start_round(5'd19, "C");
        start = 1'b1; startInput = 1'b1; code_in = 5'd19;
        repeat (78) @(negedge clk);
        expect_out("C_last_sec", 1, 0, 0, 0, 5'd1, TR_ACT);
        cyc_check();
        BTN0 = 1'b1;
        expect_out("C_tie_success", 1, 0, 1, 0, 5'd3, TR_ACT);
        cyc_check();
        BTN0 = 1'b0;

        // Wrong entries.
        do_reset();
        start_round(5'd19, "D");
        start = 1'b1; startInput = 1'b1; code_in = 5'd7;
`ifdef ATTEMPT_LIMIT_EN
        BTN0 = 1'b1;
        expect_out("D_wrong1", 1, 0, 0, 0, 5'd20, 3'd2);
        cyc_check();
        expect_out("D_held", 1, 0, 0, 0, 5'd20, 3'd2);
        cyc_check();
        BTN0 = 1'b0;
        expect_out("D_release", 1, 0, 0, 0, 5'd20, 3'd2);
        cyc_check();
        BTN0 = 1'b1;
        expect_out("D_wrong2", 1, 0, 0, 0, 5'd19, 3'd1);
        cyc_check();
        BTN0 = 1'b0;
        expect_out("D_release2", 1, 0, 0, 0, 5'd19, 3'd1);
        cyc_check();
        BTN0 = 1'b1;
        expect_out("D_wrong3_fail", 1, 1, 0, 0, 5'd3, 3'd0);
        cyc_check();
        BTN0 = 1'b0;
`else
        BTN0 = 1'b1;
        expect_out("D_wrong_fail", 1, 1, 0, 0, 5'd3, 3'd1);
        cyc_check();
        expect_out("D_fail_hold", 1, 1, 0, 0, 5'd3, 3'd1);
        cyc_check();
        BTN0 = 1'b0;
`endif

        // Abort by dropping showing mid-ARMED.
        do_reset();
        start_round(5'd19, "E");
        start = 1'b1;
        repeat (5) @(negedge clk);
        showing = 1'b0;
        expect_out("E_abort", 0, 0, 0, 0, 5'd0, 3'd0);
        cyc_check();
        expect_out("E_idle", 0, 0, 0, 0, 5'd0, 3'd0);
        cyc_check();

        // Asynchronous reset mid-SHOW.
        do_reset();
        showing = 1'b1; random = 5'd19;
        expect_out("F_show", 0, 0, 0, 0, 5'd5, TR_ACT);
        cyc_check();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        expect_out("F_async_rst", 0, 0, 0, 0, 5'd0, 3'd0);
        #1;
        pop_check();
        expect_out("F_rst_held", 0, 0, 0, 0, 5'd0, 3'd0);
        cyc_check();
        showing = 1'b0;
        rst_n = 1'b1;
        expect_out("F_idle", 0, 0, 0, 0, 5'd0, 3'd0);
        cyc_check();

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bomb_round_judge.md
Name: bomb_round_judge

Overview:
- Round-judging block that answers the game controller.
- Consumes the controller's `showing`, `start`, `startInput` and `random` signals, plus player switch/button inputs.
- Times the 5 s code display and the 20 s defuse window, and checks the entered code.
- Returns `endOfShow`, `infail`, `insuccess` and a one-cycle `repeatRst` that restarts the round.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per one-second tick (bench uses 4).
- SHOW_SEC, 5, seconds the code is displayed before input opens.
- LIMIT_SEC, 20, defuse countdown length in seconds; must be ≤31.
- RESULT_SEC, 3, seconds the success/fail result is held before `repeatRst`.
- MAX_TRIES, 3, wrong entries allowed (only used with ATTEMPT_LIMIT_EN); range 1..7.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- showing  in  1  controller: code display enabled (level).
- start  in  1  controller: countdown enabled (level).
- startInput  in  1  controller: code entry enabled (level).
- random  in  5  controller: round code; sampled on entry to SHOW.
- code_in  in  5  player switch value.
- BTN0  in  1  raw submit button (synchronous, already debounced).
- endOfShow  out  1  display phase finished (level).
- infail  out  1  round lost (level).
- insuccess  out  1  round won (level).
- repeatRst  out  1  one-cycle restart pulse.
- sec_left  out  5  seconds remaining in the current timed phase, for the display.
- tries_left  out  3  remaining attempts.

Behaviour:
- Reset: all outputs 0, state IDLE, tick counter 0, latched code 0, tries 0.
- Tick generator:
  - counts 0..TICK_DIV-1 and emits `tick` on the wrap;
  - is cleared on every state entry, so the first second of each phase is full length.
- BTN0 is edge-detected internally. `submit` is high for one cycle on a 0→1 transition; a held button gives exactly one submit.
- State machine:
  - IDLE:
    - if `showing`=1, latch `random`, load `sec_left`=SHOW_SEC, load `tries_left`=MAX_TRIES, go to SHOW;
    - level-triggered, so a round restarts automatically after `repeatRst` while `showing` stays 1.
  - SHOW:
    - decrement `sec_left` on each tick;
    - on the tick where `sec_left`=1: set `endOfShow`=1, load `sec_left`=LIMIT_SEC, go to ARMED;
    - `endOfShow` stays 1 until the state returns to IDLE.
  - ARMED:
    - the countdown decrements on a tick only while `start`=1; it freezes otherwise;
    - `submit` is honoured only while `startInput`=1;
    - on `submit` with `code_in`==latched code: go to SUCCESS;
    - on a wrong `submit`: decrement tries; if tries reach 0, go to FAIL;
    - on the tick where `sec_left`=1 (reaching 0): go to FAIL.
  - SUCCESS:
    - `insuccess`=1, load `sec_left`=RESULT_SEC, count down on ticks;
    - at 0: pulse `repeatRst` for 1 cycle, clear all flags, go to IDLE.
  - FAIL: same as SUCCESS, driving `infail`.
- Simultaneous events:
  - correct submit in the same cycle as the final tick: SUCCESS wins;
  - wrong submit on the last try in the same cycle as the final tick: FAIL (same outcome either way).
- Abort:
  - `showing`=0 in any state other than IDLE forces IDLE next cycle;
  - all flags and `sec_left` clear, no `repeatRst` pulse.
- Output latency:
  - `endOfShow`, `infail` and `insuccess` are registered, and assert the cycle after the deciding event;
  - `repeatRst` is registered, high for exactly 1 cycle;
  - `infail` and `insuccess` are never both 1.
- `sec_left` reads 0 in IDLE.

Optional Feature:
- Macro: ATTEMPT_LIMIT_EN.
- Defined:
  - wrong entries decrement `tries_left` from MAX_TRIES;
  - FAIL occurs on the entry that brings it to 0.
- Undefined:
  - the first wrong submit goes directly to FAIL;
  - `tries_left` is tied to 3'd1 while a round is active and 0 in IDLE;
  - the MAX_TRIES parameter is ignored.

Test Plan:
- TICK_DIV=4, `showing`=1, `random`=5'd19 → `endOfShow` rises after 5×4 cycles; `sec_left` reads 20 in ARMED.
- ARMED with `start`=`startInput`=1, `code_in`=19, BTN0 pulse → `insuccess`=1 the next cycle; after 12 cycles a 1-cycle `repeatRst`; a new round starts while `showing` stays 1.
- ARMED with no submit → `sec_left` counts 20→1, then `infail`=1 after 80 cycles; `insuccess` stays 0.
- ATTEMPT_LIMIT_EN, MAX_TRIES=3, `code_in`=7 submitted 3 times → `tries_left` goes 2, 1, then `infail`. Without the macro, the first wrong submit gives `infail`.
- Correct submit in the same cycle as the final countdown tick → `insuccess`=1 and `infail`=0.
- `showing` dropped to 0 mid-ARMED, and separately `rst_n` asserted mid-SHOW → all outputs 0 and state IDLE; no `repeatRst` pulse.
